mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported synchronous memory between instruction fetch and the load/store unit, so both can live in a unified memory.
- Grants at most one access per cycle: LSU has priority, with a starvation guard for fetch.
- Tracks in-flight reads with a latency pipeline and steers each returned read word to its owner.
- Exports a fetch-stall signal that drives the PC enable.

Parameters:
ADDR_W, 32, address width for both requesters and the memory.
DATA_W, 32, data width; must be a multiple of 8.
MEM_LAT, 1, memory read latency in cycles, from the enable cycle to the data-valid cycle; legal range 1..4.
STARVE_LIM, 4, consecutive denied fetch cycles before fetch is forced ahead of the LSU; legal range 1..15.

Ports:
i_clk  in  1  clock; all state updates on the rising edge
i_rst  in  1  synchronous reset, active-high
i_if_req  in  1  fetch request
i_if_addr  in  ADDR_W  fetch address
o_if_gnt  out  1  fetch granted this cycle
o_if_stall  out  1  i_if_req & ~o_if_gnt; PC enable = ~o_if_stall
o_if_rvalid  out  1  fetch read data valid
o_if_rdata  out  DATA_W  fetch read data
i_ls_req  in  1  load/store request
i_ls_we  in  1  1 = store, 0 = load
i_ls_addr  in  ADDR_W  load/store address
i_ls_wdata  in  DATA_W  store data
i_ls_strb  in  DATA_W/8  store byte enables
o_ls_gnt  out  1  load/store granted this cycle
o_ls_rvalid  out  1  load data valid
o_ls_rdata  out  DATA_W  load data
o_mem_en  out  1  memory access enable
o_mem_we  out  1  memory write enable
o_mem_addr  out  ADDR_W  memory address
o_mem_wdata  out  DATA_W  memory write data
o_mem_strb  out  DATA_W/8  memory byte enables
i_mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after an enabled read

Behaviour:
- Reset (i_rst=1 at a rising edge):
  - Starvation counter is cleared to 0.
  - All MEM_LAT tag stages are cleared, so in-flight reads are dropped and produce no rvalid.
  - During the reset cycle: o_if_rvalid=0, o_ls_rvalid=0, o_if_gnt=0, o_ls_gnt=0, o_mem_en=0, o_mem_we=0; all data outputs are 0.
- Arbitration is combinational within the cycle. Starvation counter value = cnt.
  - force = i_if_req & (cnt == STARVE_LIM).
  - o_ls_gnt = i_ls_req & ~force.
  - o_if_gnt = i_if_req & ~o_ls_gnt.
  - At most one grant per cycle.
- Memory drive:
  - Granted LSU: o_mem_en=1, o_mem_we=i_ls_we, o_mem_addr=i_ls_addr, o_mem_wdata=i_ls_wdata, o_mem_strb=i_ls_strb.
  - Granted fetch: o_mem_en=1, o_mem_we=0, o_mem_addr=i_if_addr, o_mem_strb=all ones, o_mem_wdata=0.
  - No grant: o_mem_en=0, o_mem_we=0, other memory outputs 0.
- Starvation counter (registered, 4 bits), updated each clock edge:
  - Cleared when ~i_if_req or o_if_gnt.
  - Otherwise increments, saturating at STARVE_LIM.
- Read tag pipeline (MEM_LAT stages, each {valid, owner}):
  - Stage 0 loads {1, LS} on an LSU load grant, {1, IF} on a fetch grant, else {0, x}.
  - Stores load valid=0, so a store never produces an rvalid.
  - Stages shift every cycle; there is no back-pressure.
- Read return at the last stage: if valid, assert the owner's rvalid for exactly one cycle and present i_mem_rdata on that owner's rdata. Both rdata outputs are 0 when not valid.
- Throughput: one access per cycle, back-to-back grants legal; up to MEM_LAT reads outstanding.
- Requester rule: req, addr, wdata, strb and we are held stable until gnt. The arbiter does not latch requests. A request dropped before grant is simply not serviced.
- Simultaneous read return and new grant in the same cycle are independent and both are legal.
- Reset mid-operation drops every outstanding read; no rvalid appears afterwards for those reads.

Test Plan:
- Reset, then fetch-only requests to addr 0x0, 0x4, 0x8 each cycle, MEM_LAT=1 → o_if_gnt=1 every cycle, o_if_stall=0, o_if_rvalid one cycle after each grant with matching memory words, o_ls_rvalid stays 0.
- Fetch and LSU load (addr 0x100) requested together with cnt=0 → o_ls_gnt=1, o_if_stall=1, o_mem_addr=0x100; next cycle fetch is granted and o_ls_rvalid=1 with mem[0x100].
- LSU request held continuously, fetch held, STARVE_LIM=4 → fetch denied 4 cycles, granted on the 5th with o_ls_gnt=0, then the LSU regains priority.
- LSU store, wdata=0xDEADBEEF, strb=4'b0011 → o_mem_we=1, o_mem_strb=4'b0011, no rvalid on either side at any later cycle.
- MEM_LAT=3, alternating fetch/load grants over 6 cycles → each rvalid arrives exactly 3 cycles after its grant on the correct owner, in order.
- Two reads granted, then i_rst=1 for 1 cycle before they return → no rvalid for those reads; cnt=0 afterwards.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter: shares one synchronous memory port between fetch and   |
// | the LSU, and steers each read return to the requester that issued it.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_stall,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_ls_req,
  input  logic                i_ls_we,
  input  logic [ADDR_W-1:0]   i_ls_addr,
  input  logic [DATA_W-1:0]   i_ls_wdata,
  input  logic [DATA_W/8-1:0] i_ls_strb,
  output logic                o_ls_gnt,
  output logic                o_ls_rvalid,
  output logic [DATA_W-1:0]   o_ls_rdata,
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_strb,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  localparam logic [3:0] c_LIM = 4'(STARVE_LIM);

  logic [3:0]         r_cnt;
  logic [MEM_LAT-1:0] r_vld;
  logic [MEM_LAT-1:0] r_own;
  logic [MEM_LAT-1:0] w_vld_nxt;
  logic [MEM_LAT-1:0] w_own_nxt;
  logic               w_force;
  logic               w_ls_gnt;
  logic               w_if_gnt;
  logic               w_rd_gnt;
  logic               w_ret;

  // Grants are suppressed during reset so no access leaks out of the reset cycle.
  assign w_force  = i_if_req & (r_cnt == c_LIM);
  assign w_ls_gnt = ~i_rst & i_ls_req & ~w_force;
  assign w_if_gnt = ~i_rst & i_if_req & ~w_ls_gnt;
  assign w_rd_gnt = (w_ls_gnt & ~i_ls_we) | w_if_gnt;

  assign o_ls_gnt   = w_ls_gnt;
  assign o_if_gnt   = w_if_gnt;
  assign o_if_stall = i_if_req & ~w_if_gnt;

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_strb  = '0;
    if (w_ls_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_ls_we;
      o_mem_addr  = i_ls_addr;
      o_mem_wdata = i_ls_wdata;
      o_mem_strb  = i_ls_strb;
    end else if (w_if_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_if_addr;
      o_mem_strb = '1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (~i_if_req | w_if_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt != c_LIM) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Tag pipeline: bit i describes the read issued i+1 cycles ago; owner 1 = LSU.
  generate
    if (MEM_LAT > 1) begin : g_shift
      assign w_vld_nxt = {r_vld[MEM_LAT-2:0], w_rd_gnt};
      assign w_own_nxt = {r_own[MEM_LAT-2:0], w_ls_gnt};
    end else begin : g_single
      assign w_vld_nxt = w_rd_gnt;
      assign w_own_nxt = w_ls_gnt;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= '0;
      r_own <= '0;
    end else begin
      r_vld <= w_vld_nxt;
      r_own <= w_own_nxt;
    end
  end

  assign w_ret       = ~i_rst & r_vld[MEM_LAT-1];
  assign o_ls_rvalid = w_ret & r_own[MEM_LAT-1];
  assign o_if_rvalid = w_ret & ~r_own[MEM_LAT-1];
  assign o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : '0;
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter: directed and random stimulus on MEM_LAT=1 and =3.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;
  localparam int c_LIM = 4;

  logic        clk = 1'b0;
  logic        rst, if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [3:0]  ls_strb;

  logic        a_if_gnt, a_if_stall, a_if_rvalid, a_ls_gnt, a_ls_rvalid;
  logic        a_mem_en, a_mem_we;
  logic [31:0] a_if_rdata, a_ls_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_strb;
  logic        b_if_gnt, b_if_stall, b_if_rvalid, b_ls_gnt, b_ls_rvalid;
  logic        b_mem_en, b_mem_we;
  logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_strb;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_LIM(c_LIM)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(a_if_gnt), .o_if_stall(a_if_stall), .o_if_rvalid(a_if_rvalid),
    .o_if_rdata(a_if_rdata), .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr),
    .i_ls_wdata(ls_wdata), .i_ls_strb(ls_strb), .o_ls_gnt(a_ls_gnt),
    .o_ls_rvalid(a_ls_rvalid), .o_ls_rdata(a_ls_rdata), .o_mem_en(a_mem_en),
    .o_mem_we(a_mem_we), .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata),
    .o_mem_strb(a_mem_strb), .i_mem_rdata(a_mem_rdata));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_LIM(c_LIM)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(b_if_gnt), .o_if_stall(b_if_stall), .o_if_rvalid(b_if_rvalid),
    .o_if_rdata(b_if_rdata), .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr),
    .i_ls_wdata(ls_wdata), .i_ls_strb(ls_strb), .o_ls_gnt(b_ls_gnt),
    .o_ls_rvalid(b_ls_rvalid), .o_ls_rdata(b_ls_rdata), .o_mem_en(b_mem_en),
    .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata),
    .o_mem_strb(b_mem_strb), .i_mem_rdata(b_mem_rdata));

  // Memories driven by each DUT's own port; junk data when no read was issued.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] ref_mem [256];
  logic [31:0] rd1;
  logic [31:0] rd3 [3];
  assign a_mem_rdata = rd1;
  assign b_mem_rdata = rd3[2];

  always @(posedge clk) begin
    if (a_mem_en && a_mem_we)
      for (int b = 0; b < 4; b++)
        if (a_mem_strb[b]) mem1[a_mem_addr[9:2]][8*b +: 8] <= a_mem_wdata[8*b +: 8];
    if (b_mem_en && b_mem_we)
      for (int b = 0; b < 4; b++)
        if (b_mem_strb[b]) mem3[b_mem_addr[9:2]][8*b +: 8] <= b_mem_wdata[8*b +: 8];
    rd1    <= (a_mem_en && !a_mem_we) ? mem1[a_mem_addr[9:2]] : 32'hBAD0_0001;
    rd3[0] <= (b_mem_en && !b_mem_we) ? mem3[b_mem_addr[9:2]] : 32'hBAD0_0003;
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end

  // Reference model: pending returns as (due cycle, owner, word).
  typedef struct {
    int          due;
    bit          ls;
    logic [31:0] d;
  } ret_t;
  ret_t q1[$];
  ret_t q3[$];
  int   cnt = 0;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit fi, input logic [31:0] fa,
                      input bit li, input bit lw, input logic [31:0] la,
                      input logic [31:0] lwd, input logic [3:0] lst);
    bit gl, gf, e1, e3, o1, o3;
    logic [31:0] d1, d3, rdw;
    rst = r; if_req = fi; if_addr = fa; ls_req = li; ls_we = lw;
    ls_addr = la; ls_wdata = lwd; ls_strb = lst;
    #1;
    gl = !r && li && !(fi && cnt == c_LIM);
    gf = !r && fi && !gl;
    chk("ls_gnt", a_ls_gnt, gl);
    chk("if_gnt", a_if_gnt, gf);
    chk("if_stall", a_if_stall, fi && !gf);
    chk("mem_en", a_mem_en, gl || gf);
    chk("mem_we", a_mem_we, gl && lw);
    chk("mem_addr", a_mem_addr, gl ? la : (gf ? fa : 32'h0));
    chk("mem_wdata", a_mem_wdata, gl ? lwd : 32'h0);
    chk("mem_strb", a_mem_strb, gl ? lst : (gf ? 4'hF : 4'h0));
    chk("l3_ls_gnt", b_ls_gnt, gl);
    chk("l3_if_gnt", b_if_gnt, gf);
    e1 = 0; o1 = 0; d1 = 0; e3 = 0; o3 = 0; d3 = 0;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      e1 = !r; o1 = q1[0].ls; d1 = q1[0].d; void'(q1.pop_front());
    end
    if (q3.size() > 0 && q3[0].due == cyc) begin
      e3 = !r; o3 = q3[0].ls; d3 = q3[0].d; void'(q3.pop_front());
    end
    chk("l1_if_rvalid", a_if_rvalid, e1 && !o1);
    chk("l1_ls_rvalid", a_ls_rvalid, e1 && o1);
    chk("l1_if_rdata", a_if_rdata, (e1 && !o1) ? d1 : 32'h0);
    chk("l1_ls_rdata", a_ls_rdata, (e1 && o1) ? d1 : 32'h0);
    chk("l3_if_rvalid", b_if_rvalid, e3 && !o3);
    chk("l3_ls_rvalid", b_ls_rvalid, e3 && o3);
    chk("l3_if_rdata", b_if_rdata, (e3 && !o3) ? d3 : 32'h0);
    chk("l3_ls_rdata", b_ls_rdata, (e3 && o3) ? d3 : 32'h0);
    if (r) begin
      q1.delete(); q3.delete(); cnt = 0;
    end else begin
      if (gf || (gl && !lw)) begin
        rdw = ref_mem[gl ? la[9:2] : fa[9:2]];
        q1.push_back('{cyc + 1, gl, rdw});
        q3.push_back('{cyc + 3, gl, rdw});
      end
      if (gl && lw)
        for (int b = 0; b < 4; b++)
          if (lst[b]) ref_mem[la[9:2]][8*b +: 8] = lwd[8*b +: 8];
      if (!fi || gf) cnt = 0;
      else if (cnt < c_LIM) cnt = cnt + 1;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] raddr();
    logic [31:0] v;
    v = $urandom;
    return {22'h0, v[9:2], 2'b00};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      mem1[i] = ref_mem[i];
      mem3[i] = ref_mem[i];
    end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h0, 1, 0, 32'h100, 0, 4'hF);
    // fetch-only stream
    step(0, 1, 32'h0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h4, 0, 0, 0, 0, 0);
    step(0, 1, 32'h8, 0, 0, 0, 0, 0);
    idle(3);
    // simultaneous fetch and load, LSU wins then fetch proceeds
    step(0, 1, 32'hC, 1, 0, 32'h100, 0, 4'hF);
    step(0, 1, 32'hC, 0, 0, 0, 0, 0);
    idle(3);
    // starvation guard
    for (int i = 0; i < 9; i++) step(0, 1, 32'h10, 1, 0, 32'h104, 0, 4'hF);
    idle(3);
    // partial store then read back
    step(0, 0, 0, 1, 1, 32'h108, 32'hDEADBEEF, 4'b0011);
    idle(4);
    step(0, 0, 0, 1, 0, 32'h108, 0, 4'hF);
    idle(3);
    // alternating fetch/load
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step(0, 1, 32'h20 + 4 * i, 0, 0, 0, 0, 0);
      else            step(0, 0, 0, 1, 0, 32'h200 + 4 * i, 0, 4'hF);
    end
    idle(4);
    // reset with reads outstanding
    step(0, 1, 32'h30, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h134, 0, 4'hF);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 5; i++) step(0, 1, 32'h40, 1, 0, 32'h140, 0, 4'hF);
    idle(2);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 3) != 0, raddr(),
           $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, raddr(),
           $urandom, 4'($urandom));
    end
    idle(5);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
